// File: rtl/operand_entry.sv
// rtl/operand_entry.sv - calculator keypad operand entry: builds two signed operands and an operator from key presses
module operand_entry #(
  parameter int MAX_POS_DIGITS = 6,
  parameter int MAX_NEG_DIGITS = 5
) (
  input  logic               sw_clk,
  input  logic               rst,
  input  logic               key_valid,
  input  logic [3:0]         key_code,
  input  logic               clr,
  input  logic signed [31:0] ans,
  output logic signed [31:0] operand1,
  output logic signed [31:0] operand2,
  output logic [2:0]         operator,
  output logic signed [31:0] disp_val,
  output logic [1:0]         state
);

  localparam logic [1:0] S_OP1  = 2'd0;
  localparam logic [1:0] S_OP2  = 2'd1;
  localparam logic [1:0] S_EVAL = 2'd2;
  localparam logic [1:0] S_DONE = 2'd3;

  localparam logic [3:0] POS_LIM = 4'(MAX_POS_DIGITS);
  localparam logic [3:0] NEG_LIM = 4'(MAX_NEG_DIGITS);

  logic [19:0]        mag, mag_n;
  logic               neg, neg_n;
  logic [3:0]         cnt, cnt_n;
  logic [2:0]         pend_op, pend_n;
  logic [1:0]         state_n;
  logic signed [31:0] op1_n, op2_n;
  logic [2:0]         opr_n;
  logic signed [31:0] buf_val, buf_n;
  logic [23:0]        mag10;
  logic               is_digit, is_eq, is_op, sign_key, in_range, room;
  logic [2:0]         key_op;

  assign is_digit = (key_code <= 4'd9);
  assign is_eq    = (key_code == 4'hF);
  assign is_op    = !is_digit && !is_eq;
  // A..E map onto operator codes 1..5
  assign key_op   = key_code[2:0] - 3'd1;
  assign sign_key = (key_code == 4'hD) && (cnt == 4'd0) && !neg;
  assign room     = cnt < (neg ? NEG_LIM : POS_LIM);
  assign in_range = (ans >= -32'sd99999) && (ans <= 32'sd999999);
  assign mag10    = ({4'd0, mag} * 24'd10) + {20'd0, key_code};
  assign buf_val  = neg ? -$signed({12'd0, mag}) : $signed({12'd0, mag});
  assign buf_n    = neg_n ? -$signed({12'd0, mag_n}) : $signed({12'd0, mag_n});

  always_comb begin
    state_n = state;
    mag_n   = mag;
    neg_n   = neg;
    cnt_n   = cnt;
    pend_n  = pend_op;
    op1_n   = operand1;
    op2_n   = operand2;
    opr_n   = operator;
    if (key_valid) begin
      case (state)
        S_OP1, S_OP2: begin
          if (is_digit) begin
            if (room && !(key_code == 4'd0 && cnt == 4'd0)) begin
              mag_n = mag10[19:0];
              cnt_n = cnt + 4'd1;
            end
          end else if (sign_key) begin
            neg_n = 1'b1;
          end else if (is_op) begin
            if (state == S_OP1) begin
              pend_n  = key_op;
              mag_n   = 20'd0;
              neg_n   = 1'b0;
              cnt_n   = 4'd0;
              state_n = S_OP2;
            end else if (cnt == 4'd0 && !neg) begin
              pend_n = key_op;
            end
          end else if (state == S_OP2) begin
            opr_n   = pend_op;
            state_n = S_EVAL;
          end
        end
        S_DONE: begin
          if (is_digit) begin
            op1_n   = 32'sd0;
            op2_n   = 32'sd0;
            opr_n   = 3'd0;
            mag_n   = {16'd0, key_code};
            neg_n   = 1'b0;
            cnt_n   = {3'd0, key_code != 4'd0};
            state_n = S_OP1;
          end else if (is_op && in_range) begin
            op1_n   = ans;
            op2_n   = 32'sd0;
            opr_n   = 3'd0;
            pend_n  = key_op;
            mag_n   = 20'd0;
            neg_n   = 1'b0;
            cnt_n   = 4'd0;
            state_n = S_OP2;
          end
        end
        default: ;
      endcase
    end
    if (state == S_EVAL) state_n = S_DONE;
    // the operand under entry follows the buffer until its state is left
    if (state == S_OP1 && state_n == S_OP1) op1_n = buf_n;
    if (state == S_OP2 && state_n == S_OP2) op2_n = buf_n;
  end

  always_comb begin
    case (state)
      S_EVAL:  disp_val = operand2;
      S_DONE:  disp_val = ans;
      default: disp_val = buf_val;
    endcase
  end

  always_ff @(posedge sw_clk or negedge rst) begin
    if (!rst || clr) begin
      state    <= S_OP1;
      mag      <= 20'd0;
      neg      <= 1'b0;
      cnt      <= 4'd0;
      pend_op  <= 3'd0;
      operand1 <= 32'sd0;
      operand2 <= 32'sd0;
      operator <= 3'd0;
    end else begin
      state    <= state_n;
      mag      <= mag_n;
      neg      <= neg_n;
      cnt      <= cnt_n;
      pend_op  <= pend_n;
      operand1 <= op1_n;
      operand2 <= op2_n;
      operator <= opr_n;
    end
  end

endmodule

// File: tb/tb_operand_entry.sv
// tb/tb_operand_entry.sv - scoreboard bench for operand_entry
module tb_operand_entry;

  logic               sw_clk = 1'b0;
  logic               rst = 1'b0;
  logic               key_valid = 1'b0;
  logic [3:0]         key_code = 4'd0;
  logic               clr = 1'b0;
  logic signed [31:0] ans = 32'sd0;
  logic signed [31:0] operand1, operand2, disp_val;
  logic [2:0]         operator;
  logic [1:0]         state;

  operand_entry dut (
    .sw_clk(sw_clk), .rst(rst), .key_valid(key_valid), .key_code(key_code),
    .clr(clr), .ans(ans), .operand1(operand1), .operand2(operand2),
    .operator(operator), .disp_val(disp_val), .state(state)
  );

  always #5 sw_clk = ~sw_clk;

  typedef struct packed {
    logic signed [31:0] op1;
    logic signed [31:0] op2;
    logic [2:0]         opr;
    logic [1:0]         st;
    logic signed [31:0] disp;
  } exp_t;

  exp_t  sb[$];
  string tags[$];
  int    n_assert = 0;
  int    n_fail = 0;

  task automatic check_val(input string tag, input logic signed [31:0] got, input logic signed [31:0] exp);
    n_assert++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic sb_push(input string tag, input logic signed [31:0] e1, input logic signed [31:0] e2,
                         input logic [2:0] eo, input logic [1:0] es, input logic signed [31:0] ed);
    exp_t e;
    e.op1 = e1; e.op2 = e2; e.opr = eo; e.st = es; e.disp = ed;
    sb.push_back(e);
    tags.push_back(tag);
  endtask

  task automatic sb_check();
    exp_t  e;
    string t;
    if (sb.size() == 0) begin
      n_assert++;
      n_fail++;
      $display("FAIL scoreboard: got empty queue expected an entry");
      return;
    end
    e = sb.pop_front();
    t = tags.pop_front();
    check_val({t, ".operand1"}, operand1, e.op1);
    check_val({t, ".operand2"}, operand2, e.op2);
    check_val({t, ".operator"}, $signed({29'd0, operator}), $signed({29'd0, e.opr}));
    check_val({t, ".state"}, $signed({30'd0, state}), $signed({30'd0, e.st}));
    check_val({t, ".disp_val"}, disp_val, e.disp);
  endtask

  // one clock with the given inputs, then compare against the pushed expectation
  task automatic step(input logic v, input logic [3:0] k, input logic c, input string tag,
                      input logic signed [31:0] e1, input logic signed [31:0] e2,
                      input logic [2:0] eo, input logic [1:0] es, input logic signed [31:0] ed);
    sb_push(tag, e1, e2, eo, es, ed);
    key_valid = v;
    key_code  = k;
    clr       = c;
    @(negedge sw_clk);
    key_valid = 1'b0;
    clr       = 1'b0;
    sb_check();
  endtask

  task automatic press(input logic [3:0] k);
    key_valid = 1'b1;
    key_code  = k;
    @(negedge sw_clk);
    key_valid = 1'b0;
  endtask

  initial begin
    @(negedge sw_clk);
    sb_push("reset", 0, 0, 0, 0, 0);
    sb_check();
    rst = 1'b1;
    @(negedge sw_clk);

    ans = 32'sd168;
    press(4'h1); press(4'h2);
    step(1, 4'h3, 0, "op1_123", 123, 0, 0, 0, 123);
    step(1, 4'hC, 0, "plus", 123, 0, 0, 1, 0);
    press(4'h4);
    step(1, 4'h5, 0, "op2_45", 123, 45, 0, 1, 45);
    step(1, 4'hF, 0, "eval", 123, 45, 3, 2, 45);
    step(0, 4'h0, 0, "done", 123, 45, 3, 3, 168);

    step(1, 4'hB, 0, "chain_div", 168, 0, 0, 1, 0);
    press(4'h4);
    step(1, 4'hF, 0, "chain_eval", 168, 4, 2, 2, 4);
    step(0, 4'h0, 0, "chain_done", 168, 4, 2, 3, 168);
    ans = 32'h00EE0000;
    step(1, 4'hC, 0, "ans_ee", 168, 4, 2, 3, 32'h00EE0000);
    ans = 32'h00CC0000;
    step(1, 4'hA, 0, "ans_cc", 168, 4, 2, 3, 32'h00CC0000);
    ans = 32'sd1000000;
    step(1, 4'hC, 0, "ans_1e6", 168, 4, 2, 3, 1000000);
    ans = -32'sd100000;
    step(1, 4'hD, 0, "ans_m100000", 168, 4, 2, 3, -100000);
    ans = -32'sd99999;
    step(1, 4'hE, 0, "ans_m99999", -99999, 0, 0, 1, 0);
    press(4'h7);
    step(1, 4'hF, 0, "mod_eval", -99999, 7, 5, 2, 7);
    step(0, 4'h0, 0, "mod_done", -99999, 7, 5, 3, -99999);
    ans = 32'sd999999;
    step(1, 4'hA, 0, "ans_999999", 999999, 0, 0, 1, 0);
    step(1, 4'hF, 0, "empty_eval", 999999, 0, 1, 2, 0);
    step(0, 4'h0, 0, "empty_done", 999999, 0, 1, 3, 999999);
    step(1, 4'hF, 0, "done_eq", 999999, 0, 1, 3, 999999);
    step(1, 4'h8, 0, "done_digit", 0, 0, 0, 0, 8);
    step(0, 4'h0, 0, "done_digit_trk", 8, 0, 0, 0, 8);

    step(1, 4'h5, 1, "clr_key", 0, 0, 0, 0, 0);
    step(0, 4'h3, 0, "no_valid", 0, 0, 0, 0, 0);
    press(4'h1); press(4'h2);
    step(1, 4'hC, 0, "pre_rst", 12, 0, 0, 1, 0);
    #2 rst = 1'b0;
    #1;
    sb_push("async_rst", 0, 0, 0, 0, 0);
    sb_check();
    @(negedge sw_clk);
    rst = 1'b1;
    press(4'h1); press(4'h2);
    step(1, 4'hC, 0, "pre_clr", 12, 0, 0, 1, 0);
    step(0, 4'h0, 1, "clr", 0, 0, 0, 0, 0);

    for (int d = 1; d <= 6; d++) press(4'(d));
    step(1, 4'h7, 0, "pos_limit", 123456, 0, 0, 0, 123456);
    step(0, 4'h0, 1, "clr2", 0, 0, 0, 0, 0);
    press(4'hD);
    for (int d = 1; d <= 5; d++) press(4'(d));
    step(1, 4'h6, 0, "neg_limit", -12345, 0, 0, 0, -12345);
    step(0, 4'h0, 1, "clr3", 0, 0, 0, 0, 0);

    press(4'hD); press(4'h5);
    step(1, 4'hA, 0, "neg_mul", -5, 0, 0, 1, 0);
    press(4'hD);
    step(1, 4'h3, 0, "neg_op2", -5, -3, 0, 1, -3);
    step(1, 4'hF, 0, "neg_eval", -5, -3, 1, 2, -3);
    step(0, 4'h0, 1, "clr4", 0, 0, 0, 0, 0);

    press(4'h0);
    step(1, 4'h0, 0, "lead_zero", 0, 0, 0, 0, 0);
    step(1, 4'h7, 0, "after_zero", 7, 0, 0, 0, 7);
    press(4'hC);
    step(1, 4'hA, 0, "op_replace", 7, 0, 0, 1, 0);
    press(4'h9);
    step(1, 4'hF, 0, "replace_eval", 7, 9, 1, 2, 9);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/operand_entry.md
OPERAND_ENTRY -- requirements
Module: operand_entry

Interface
REQ-001 SHALL have parameter MAX_POS_DIGITS, default 6: digit limit for a positive operand.
REQ-002 SHALL have parameter MAX_NEG_DIGITS, default 5: digit limit for a negative operand.
REQ-003 SHALL have port sw_clk  input  1  clock; all state changes on its rising edge.
REQ-004 SHALL have port rst  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have port key_valid  input  1  one-cycle pulse per debounced key press.
REQ-006 SHALL have port key_code  input  4  key id: 0-9 digit, A '*', B '/', C '+', D '-', E '%', F '='.
REQ-007 SHALL have port clr  input  1  synchronous clear, priority over key_valid.
REQ-008 SHALL have port ans  input  32 signed  result from the downstream arithmetic stage, used for chaining.
REQ-009 SHALL have port operand1  output  32 signed  first operand, registered.
REQ-010 SHALL have port operand2  output  32 signed  second operand, registered.
REQ-011 SHALL have port operator  output  3  0 none, 1 '*', 2 '/', 3 '+', 4 '-', 5 '%'.
REQ-012 SHALL have port disp_val  output  32 signed  value currently being entered (ans in S_DONE).
REQ-013 SHALL have port state  output  2  S_OP1=0, S_OP2=1, S_EVAL=2, S_DONE=3.

Function
REQ-014 SHALL ignore key_code whenever key_valid=0.
REQ-015 SHALL keep an entry buffer: magnitude (20 bit), neg flag, digit count; operand value = neg ? -mag : mag.
REQ-016 Digit in S_OP1/S_OP2: SHALL set mag = mag*10+d and count+1 if count < limit (MAX_NEG_DIGITS when neg, else MAX_POS_DIGITS); otherwise ignored.
REQ-017 Digit 0 with count=0: SHALL leave mag=0 and count=0 (no leading zeros).
REQ-018 'D' with count=0 and neg=0 in S_OP1/S_OP2: SHALL set neg=1 (sign entry), not an operator.
REQ-019 S_OP1: operator key (A-E, or D when count>0 or neg=1): SHALL latch pending op, clear buffer, go S_OP2; '=' ignored.
REQ-020 S_OP1 operand1 SHALL track the buffer value every cycle; S_OP2 operand2 likewise; the other operand holds.
REQ-021 S_OP2 operator key with count=0 and neg=0 (other than D): SHALL replace pending op, stay S_OP2.
REQ-022 S_OP2 '=': SHALL drive operator=pending op, go S_EVAL; operand1/operand2 frozen.
REQ-023 S_EVAL: SHALL last exactly one cycle, ignore keys, then go S_DONE; operator held through S_EVAL and S_DONE.
REQ-024 S_DONE digit: SHALL clear both operands and operator to 0, start buffer with that digit, go S_OP1.
REQ-025 S_DONE operator key: if -99999 <= ans <= 999999 SHALL load operand1=ans, operand2=0, operator=0, latch pending op, go S_OP2; else ignored.
REQ-026 S_DONE '=': SHALL be ignored.
REQ-027 Out-of-range ans values (including 0x00CC0000 and 0x00EE0000) SHALL never load into operand1.
REQ-028 disp_val SHALL equal the buffer value in S_OP1/S_OP2, operand2 in S_EVAL, ans in S_DONE.
REQ-029 clr=1: SHALL apply reset values at the next edge regardless of state or key.

Reset
REQ-030 rst=0 SHALL immediately force operand1=0, operand2=0, operator=0, disp_val=0, state=S_OP1, buffer cleared, pending op=0.
REQ-031 Deassertion SHALL resume normal operation at the first following sw_clk edge.

Verification
REQ-032 Keys 1,2,3,C,4,5,F -> operand1=123, operand2=45, operator=3, state S_EVAL then S_DONE.
REQ-033 Keys 1..7 (seven digits) -> operand1=123456; D,1,2,3,4,5,6 -> operand1=-12345.
REQ-034 Keys D,5,A,D,3,F -> operand1=-5, operand2=-3, operator=1.
REQ-035 S_DONE, ans=168, keys B,4,F -> operand1=168, operand2=4, operator=2; S_DONE, ans=0x00EE0000, key C -> no change, state S_DONE.
REQ-036 Keys 1,2,C then rst=0 mid-cycle -> all outputs 0, state S_OP1 without waiting for a clock; same via clr -> at next edge.
REQ-037 Keys 0,0,7,C,A,9,F -> operand1=7, operator=1 ('*' replaced '+'), operand2=9.
